clockbuf: RTL and testbench

CLOCKBUF -- requirements
Module: clockbuf

---
 rtl/clockbuf_pkg.sv | 22 ++
 rtl/clockbuf_rst_sync.sv | 29 ++
 rtl/clockbuf.sv | 94 +++++++++
 tb/tb_clockbuf.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clockbuf_pkg.sv
//==============================================================================
// Module : clockbuf_pkg
// Brief  : Default constants, counter type and helpers shared by clockbuf.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package clockbuf_pkg;

    localparam int c_div_default   = 4;
    localparam int c_cnt_w_default = 16;

    typedef logic [c_cnt_w_default-1:0] cnt_t;

    // Width of the half-period counter; at least one bit even when DIV == 2.
    function automatic int div_cnt_width(input int div);
        return ((div / 2) > 1) ? $clog2(div / 2) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clockbuf_rst_sync.sv
//==============================================================================
// Module : clockbuf_rst_sync
// Brief  : Reset synchronizer; asserts asynchronously, releases on the 2nd clk
//          rising edge after rst falls.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clockbuf_rst_sync (
    input  logic clk,
    input  logic rst,
    output logic o_run
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_run = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/clockbuf.sv
//==============================================================================
// Module : clockbuf
// Brief  : Clock buffer with glitch-free gated copy, optional DIV divider
//          (built only when CLOCKBUF_DIV_EN is defined) and edge counter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clockbuf
    import clockbuf_pkg::*;
#(
    parameter int DIV   = c_div_default,
    parameter int CNT_W = c_cnt_w_default
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             en,
    output logic             bclk,
    output logic             bclk_g,
    output logic             bclk_div,
    output logic [CNT_W-1:0] cyc_cnt
);

    generate
        if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_div_check
            $error("clockbuf: DIV must be even and at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_run;
    logic             r_en_q;
    logic [CNT_W-1:0] r_cyc_cnt;

    assign bclk = mclk;

    clockbuf_rst_sync u_rst_sync (
        .clk   (mclk),
        .rst   (rst),
        .o_run (w_run)
    );

    // Falling-edge capture keeps en_q stable for the whole high phase.
    always_ff @(negedge mclk or posedge rst) begin
        if (rst) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= en;
        end
    end

    assign bclk_g = mclk & r_en_q;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt <= '0;
        end else if (w_run) begin
            r_cyc_cnt <= r_cyc_cnt + c_cnt_one;
        end
    end

    assign cyc_cnt = r_cyc_cnt;

`ifdef CLOCKBUF_DIV_EN
    localparam int              c_div_w    = div_cnt_width(DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'((DIV / 2) - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_div;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_div     <= 1'b0;
        end else if (w_run) begin
            if (r_div_cnt == c_div_last) begin
                r_div_cnt <= '0;
                r_div     <= ~r_div;
            end else begin
                r_div_cnt <= r_div_cnt + c_div_one;
            end
        end
    end

    assign bclk_div = r_div;
`else
    assign bclk_div = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clockbuf.sv
//==============================================================================
// Module : tb_clockbuf
// Brief  : Self-checking bench for clockbuf (DIV=4, CNT_W=4).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_clockbuf;

    localparam int DIV   = 4;
    localparam int CNT_W = 4;
`ifdef CLOCKBUF_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic             mclk = 1'b0;
    logic             rst  = 1'b0;
    logic             en;
    logic             bclk;
    logic             bclk_g;
    logic             bclk_div;
    logic [CNT_W-1:0] cyc_cnt;

    clockbuf #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .mclk     (mclk),
        .rst      (rst),
        .en       (en),
        .bclk     (bclk),
        .bclk_g   (bclk_g),
        .bclk_div (bclk_div),
        .cyc_cnt  (cyc_cnt)
    );

    always #10 mclk = ~mclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset fall, counted edges, captured enable.
    int   m_since = 0;
    int   m_n     = 0;
    logic m_enq   = 1'b0;

    always @(posedge mclk or posedge rst) begin
        if (rst) begin
            m_since = 0;
            m_n     = 0;
        end else begin
            if (m_since < 3) m_since = m_since + 1;
            if (m_since >= 3) m_n = m_n + 1;
        end
    end

    always @(negedge mclk or posedge rst) begin
        if (rst) m_enq = 1'b0;
        else     m_enq = en;
    end

    function automatic int exp_cnt();
        return m_n % (1 << CNT_W);
    endfunction

    function automatic int exp_div();
        return DIV_ON ? ((m_n / (DIV / 2)) % 2) : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_bclk"}, 32'(bclk), 32'(mclk));
        check({tag, "_g"},    32'(bclk_g), 32'(mclk & m_enq));
        check({tag, "_cnt"},  32'(cyc_cnt), 32'(exp_cnt()));
        check({tag, "_div"},  32'(bclk_div), 32'(exp_div()));
    endtask

    // Edge timestamps for phase/period checks.
    longint t_mr = 0, t_br = 0, t_br_prev = 0;
    longint t_dr = 0, t_dr_prev = 0, t_df = 0;
    int     div_rises = 0;

    always @(posedge mclk) t_mr = $time;
    always @(posedge bclk) begin
        t_br_prev = t_br;
        t_br      = $time;
    end
    always @(posedge bclk_div) begin
        t_dr_prev = t_dr;
        t_dr      = $time;
        div_rises++;
    end
    always @(negedge bclk_div) t_df = $time;

    task automatic at(input longint t);
        if (t > $time) #(t - $time);
    endtask

    typedef struct {
        int   t;
        logic rst;
        bit   drv_en;
        logic en;
        bit   chk;
        logic bclk;
        logic g;
        int   cnt;
        logic div;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //          t    rst drv en  chk bclk g  cnt div
        vec[0]  = '{0,   0,  0,  0,  0,  0,   0, 0,  0};
        vec[1]  = '{2,   1,  0,  0,  1,  0,   0, 0,  0};
        vec[2]  = '{12,  1,  0,  0,  1,  1,   0, 0,  0};
        vec[3]  = '{22,  1,  1,  1,  1,  0,   0, 0,  0};
        vec[4]  = '{25,  0,  0,  0,  1,  0,   0, 0,  0};
        vec[5]  = '{32,  0,  0,  0,  1,  1,   0, 0,  0};
        vec[6]  = '{45,  0,  0,  0,  1,  0,   0, 0,  0};
        vec[7]  = '{52,  0,  0,  0,  1,  1,   1, 0,  0};
        vec[8]  = '{72,  0,  0,  0,  1,  1,   1, 1,  0};
        vec[9]  = '{82,  0,  0,  0,  1,  0,   0, 1,  0};
        vec[10] = '{92,  0,  0,  0,  1,  1,   1, 2,  1};
        vec[11] = '{112, 0,  0,  0,  1,  1,   1, 3,  1};
        vec[12] = '{132, 0,  0,  0,  1,  1,   1, 4,  0};
        vec[13] = '{152, 0,  0,  0,  1,  1,   1, 5,  0};
        vec[14] = '{172, 0,  0,  0,  1,  1,   1, 6,  1};

        for (int i = 0; i < NVEC; i++) begin
            at(longint'(vec[i].t));
            rst = vec[i].rst;
            if (vec[i].drv_en) en = vec[i].en;
            #1;
            check("tbl_bclk", 32'(bclk), 32'(vec[i].bclk));
            if (vec[i].chk) begin
                check("tbl_g",   32'(bclk_g), 32'(vec[i].g));
                check("tbl_cnt", 32'(cyc_cnt), 32'(vec[i].cnt));
                check("tbl_div", 32'(bclk_div), 32'(DIV_ON ? vec[i].div : 1'b0));
                check_all("tbl_model");
            end
        end

        check("bclk_phase",  32'(t_br), 32'(t_mr));
        check("bclk_period", 32'(t_br - t_br_prev), 32'd20);
        check("div_rises",   32'(div_rises), DIV_ON ? 32'd2 : 32'd0);
`ifdef CLOCKBUF_DIV_EN
        check("div_period", 32'(t_dr - t_dr_prev), 32'd80);
        check("div_high",   32'(t_df - t_dr_prev), 32'd40);
`endif

        // Enable changes during the high phase must not cut or start a pulse.
        at(175); en = 1'b0;
        at(212); en = 1'b1;
        at(215); check("g_on_midhigh_a", 32'(bclk_g), 32'd0);
        at(219); check("g_on_midhigh_b", 32'(bclk_g), 32'd0);
        at(232); check("g_first_pulse_a", 32'(bclk_g), 32'd1);
        at(239); check("g_first_pulse_b", 32'(bclk_g), 32'd1);
        at(252); en = 1'b0;
        at(255); check("g_off_hold_a", 32'(bclk_g), 32'd1);
        at(259); check("g_off_hold_b", 32'(bclk_g), 32'd1);
        at(261); check("g_off_low", 32'(bclk_g), 32'd0);
        at(275); check("g_off_next", 32'(bclk_g), 32'd0);

        // Reset in the middle of operation at cyc_cnt == 5.
        at(276); en  = 1'b1;
        at(285); rst = 1'b1;
        at(287); rst = 1'b0;
        at(413);
        check("mid_cnt5", 32'(cyc_cnt), 32'd5);
        check("mid_g_hi", 32'(bclk_g), 32'd1);
        check_all("mid_pre");
        at(415); rst = 1'b1;
        at(416);
        check("mid_rst_cnt",  32'(cyc_cnt), 32'd0);
        check("mid_rst_g",    32'(bclk_g), 32'd0);
        check("mid_rst_div",  32'(bclk_div), 32'd0);
        check("mid_rst_bclk", 32'(bclk), 32'd1);
        at(418); rst = 1'b0;
        at(431); check("resume_e1", 32'(cyc_cnt), 32'd0);
        at(451); check("resume_e2", 32'(cyc_cnt), 32'd0);
        at(471); check("resume_e3", 32'(cyc_cnt), 32'd1);
        check_all("resume");

        // Randomized phase against the model, including async reset pulses.
        for (int c = 0; c < 300; c++) begin
            @(posedge mclk); #1;
            check_all("rnd_hi");
            #(2 + $urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                #1 check_all("rnd_rst_hi");
            end else begin
                en = 1'($urandom_range(0, 1));
            end
            @(negedge mclk); #1;
            check_all("rnd_lo");
            #($urandom_range(1, 5));
            if (rst && ($urandom_range(0, 2) != 0)) rst = 1'b0;
            else if ($urandom_range(0, 24) == 0) rst = 1'b1;
            else en = 1'($urandom_range(0, 1));
            #1 check_all("rnd_mid");
        end

        // Counter wrap at CNT_W = 4.
        @(negedge mclk); #3 rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge mclk);
        #1 check("wrap_uncounted", 32'(cyc_cnt), 32'd0);
        repeat (15) @(posedge mclk);
        #1;
        check("wrap_15", 32'(cyc_cnt), 32'd15);
        check("wrap_15_div", 32'(bclk_div), DIV_ON ? 32'd1 : 32'd0);
        @(posedge mclk); #1;
        check("wrap_0", 32'(cyc_cnt), 32'd0);
        @(posedge mclk); #1;
        check("wrap_1", 32'(cyc_cnt), 32'd1);
        check_all("wrap_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
